// File: rtl/alu_pkg.sv
// Shared ALU definitions: alucontrol codes (also used by the decoder) and the
// execution-unit FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_MUL   = 4'b0011;
  localparam logic [3:0] ALU_AUIPC = 4'b0100;
  localparam logic [3:0] ALU_BRSUB = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle, fixed
// WIDTH iterations, low WIDTH bits of the product only.
module mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] product,
  output logic             last
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;

  // product is the accumulator after the current step, so the caller can
  // register it on the final iteration without an extra cycle.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign last    = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (load) begin
      mcand  <= multiplicand;
      mplier <= multiplier;
      acc    <= '0;
      count  <= '0;
    end else if (step) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Registered RISC-V execution unit: single-cycle ALU ops plus an iterative
// multiply, under a start/busy/done handshake.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] single_res;
  logic             single_ill;
  logic [WIDTH-1:0] res_d;
  logic             ill_d;
  logic             complete;
  logic             load;
  logic             step;
  logic             last;
  logic [WIDTH-1:0] product;

  always_comb begin
    single_res = '0;
    single_ill = 1'b0;
    case (alucontrol)
      ALU_AND:   single_res = a & b;
      ALU_ADD:   single_res = a + b;
      ALU_AUIPC: single_res = a + b;
      ALU_BRSUB: single_res = a - b;
      ALU_SUB:   single_res = a - b;
      ALU_SLL:   single_res = a << b[SHW-1:0];
      ALU_SLT:   single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_MUL:   single_res = '0;
      default:   single_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    complete   = 1'b0;
    res_d      = single_res;
    ill_d      = single_ill;
    case (state)
      IDLE: begin
        if (start) begin
          if (alucontrol == ALU_MUL) begin
            load       = 1'b1;
            state_next = MUL;
          end else begin
            complete = 1'b1;
          end
        end
      end
      MUL: begin
        step = 1'b1;
        if (last) begin
          complete   = 1'b1;
          res_d      = product;
          ill_d      = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == MUL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      result  <= '0;
      zero    <= 1'b1;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      done  <= complete;
      if (complete) begin
        result  <= res_d;
        zero    <= (res_d == '0);
        illegal <= ill_d;
      end
    end
  end

  mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .step         (step),
    .multiplicand (a),
    .multiplier   (b),
    .product      (product),
    .last         (last)
  );

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec with hand-computed expectations.
module tb_alu_exec;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  alucontrol;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic        done;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  alu_exec #(
    .WIDTH(32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .result     (result),
    .zero       (zero),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request for the acceptance cycle; returns #1 into cycle 1.
  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    alucontrol = op;
    a          = x;
    b          = y;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    alucontrol = 4'b0000;
    a          = '0;
    b          = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 32'h0);
    check("rst_zero", zero, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    reset = 1'b0;
    next_cycle();

    // 1: add
    issue(4'b0010, 32'd5, 32'd7);
    check("add_done", done, 1);
    check("add_result", result, 32'd12);
    check("add_zero", zero, 0);
    check("add_busy", busy, 0);
    next_cycle();
    check("add_done_pulse", done, 0);
    check("add_result_hold", result, 32'd12);

    // 2: subtracts and back-to-back issue
    issue(4'b0110, 32'd9, 32'd9);
    check("sub_result", result, 32'h0);
    check("sub_zero", zero, 1);
    issue(4'b0101, 32'd3, 32'd5);
    check("brsub_result", result, 32'hFFFF_FFFE);
    check("brsub_zero", zero, 0);
    next_cycle();
    alucontrol = 4'b0010; a = 32'd1; b = 32'd1; start = 1'b1;
    next_cycle();
    check("b2b_done1", done, 1);
    check("b2b_result1", result, 32'd2);
    alucontrol = 4'b0010; a = 32'd2; b = 32'd3;
    next_cycle();
    start = 1'b0;
    check("b2b_done2", done, 1);
    check("b2b_result2", result, 32'd5);
    next_cycle();
    check("b2b_done_end", done, 0);

    // 3: shift and set-less-than
    issue(4'b0111, 32'd1, 32'h23);
    check("sll_result", result, 32'd8);
    issue(4'b1000, 32'hFFFF_FFFF, 32'd1);
    check("slt_neg_lt", result, 32'd1);
    issue(4'b1000, 32'd1, 32'hFFFF_FFFF);
    check("slt_pos_lt", result, 32'd0);
    check("slt_zero", zero, 1);
    issue(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
    check("and_result", result, 32'h00F0_1200);

    // 4: multiply with ignored starts while busy
    issue(4'b0011, 32'h0001_0003, 32'd5);
    for (int c = 1; c <= 32; c++) begin
      check("mul_busy", busy, 1);
      check("mul_no_done", done, 0);
      if (c == 5 || c == 20) begin
        alucontrol = 4'b0010; a = 32'd100; b = 32'd200; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      next_cycle();
    end
    start = 1'b0;
    check("mul_done", done, 1);
    check("mul_busy_end", busy, 0);
    check("mul_result", result, 32'h0005_000F);
    check("mul_zero", zero, 0);
    check("mul_illegal", illegal, 0);
    next_cycle();
    check("mul_no_extra_done", done, 0);
    check("mul_result_hold", result, 32'h0005_000F);

    // 5: all-ones square, then reset mid-multiply
    issue(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (32) @(posedge clk);
    #1;
    check("mulff_done", done, 1);
    check("mulff_result", result, 32'd1);
    next_cycle();
    issue(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    #1;
    check("mulrst_busy_pre", busy, 1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    check("mulrst_busy", busy, 0);
    check("mulrst_done", done, 0);
    check("mulrst_result", result, 32'h0);
    check("mulrst_zero", zero, 1);
    check("mulrst_illegal", illegal, 0);
    for (int c = 0; c < 40; c++) begin
      check("mulrst_no_done", done, 0);
      next_cycle();
    end
    issue(4'b0010, 32'd2, 32'd2);
    check("post_rst_done", done, 1);
    check("post_rst_result", result, 32'd4);

    // 6: unsupported code
    next_cycle();
    issue(4'b1111, 32'd1, 32'd1);
    check("ill_done", done, 1);
    check("ill_flag", illegal, 1);
    check("ill_result", result, 32'h0);
    check("ill_zero", zero, 1);
    next_cycle();
    check("ill_hold", illegal, 1);
    issue(4'b0010, 32'd1, 32'd1);
    check("ill_clear", illegal, 0);
    check("ill_clear_result", result, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
